complex_op_packer: RTL and testbench
====================================

Name: complex_op_packer

Overview:
- Transmitter side of the operand interface of the complex-number multiplier (op_val / op_ready / op_data).
- Accepts a serial stream of DATA_WIDTH-wide words on a valid/ready input and packs every four words into one 4*DATA_WIDTH operand: {a_re, a_im, b_re, b_im}.
- Presents the packed operand to the multiplier with a valid/ready handshake.
- Double-buffered (assembly register + output register), so input throughput is one word per cycle while the multiplier accepts.

Parameters:
- DATA_WIDTH, 8, width of one operand component / input word.
- CNT_WIDTH, 8, width of the sent-operand counter.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous reset, active low.
- sw_rst  input  1  synchronous software reset, active high.
- in_val  input  1  input word valid.
- in_ready  output  1  block can accept an input word.
- in_data  input  DATA_WIDTH  input word.
- in_sof  input  1  marks in_data as word 0 (a_re) of a new operand.
- op_val  output  1  packed operand valid.
- op_ready  input  1  multiplier ready to take the operand.
- op_data  output  4*DATA_WIDTH  packed operand.
- frame_err  output  1  one-cycle pulse: partial operand discarded on in_sof resync.
- op_cnt  output  CNT_WIDTH  number of operands handed over, modulo 2^CNT_WIDTH.

Behaviour:
- Reset: rstn is asynchronous, active low; the clock is clk.
  - rstn=0 or sw_rst=1 clears: idx=0, asm_full=0, assembly register=0, op_val=0, op_data=0, frame_err=0, op_cnt=0.
  - sw_rst has priority over all other events in that cycle. Any partial or pending operand is dropped.
- Input accept: in_val & in_ready.
  - in_ready = ~asm_full & ~sw_rst, so it is 1 out of reset.
- Word placement by idx (0..3):
  - idx 0 -> bits [4DW-1:3DW] (a_re)
  - idx 1 -> [3DW-1:2DW] (a_im)
  - idx 2 -> [2DW-1:DW] (b_re)
  - idx 3 -> [DW-1:0] (b_im)
  - idx increments on every accept and wraps 3 -> 0.
- in_sof:
  - On an accepted word with idx=0, in_sof is ignored. in_sof is not required.
  - On an accepted word with idx!=0: partial words are discarded, frame_err pulses high for the next cycle, the word is stored as a_re, and idx becomes 1.
- Output slot free condition: free = ~op_val | op_ready.
- Completing an operand (accepting the idx=3 word):
  - If free: the output register loads the complete operand and op_val=1 from the next cycle (latency 1 cycle from the 4th word).
  - Else: the operand is held in the assembly register, asm_full=1 and in_ready=0.
- Pending operand: while asm_full & free, the output register loads the assembly register next cycle and asm_full clears.
- Output hold: while op_val & ~op_ready, op_data and op_val are held stable.
- op_val drops the cycle after a handshake unless a new operand is loaded that same edge. Back-to-back operands are allowed.
- op_cnt increments by 1 on each op_val & op_ready and wraps from 2^CNT_WIDTH-1 to 0.
- States (derived): EMPTY (op_val=0, asm_full=0), ONE (op_val=1, asm_full=0), FULL (op_val=1, asm_full=1).
  - ONE -> FULL: 4th word completes while op_ready=0.
  - FULL -> ONE: op_ready=1; the assembly register moves to the output.
- Simultaneous events:
  - Handshake and 4th-word completion in the same cycle: the new operand goes directly to the output register; op_val stays 1.
- Arithmetic: none; pure packing, no sign handling.

Test Plan:
- DW=8: send 0x01,0x02,0x03,0x04 (sof on first), op_ready=1 -> op_val high one cycle after the 4th accept, op_data=0x01020304, op_cnt=1.
- op_ready=0, stream 8 words 0x10..0x17:
  - op_data holds 0x10111213; after the 8th word in_ready=0.
  - Raise op_ready -> 0x10111213 then 0x14151617 are handed over on consecutive cycles; in_ready returns to 1.
- Send 0xAA,0xBB, then 0x11(sof),0x22,0x33,0x44 -> frame_err pulses once; only operand 0x11223344 is emitted.
- op_ready held 1, stream 12 words continuously -> in_ready never drops; 3 operands issued; op_cnt=3.
- Preload op_cnt to 255 via 255 operands, send one more -> op_cnt=0.
- Assert sw_rst with 2 words collected and an operand pending on the output -> next cycle op_val=0, op_cnt=0, in_ready=1. The next 4 words form a fresh operand.

Source files
------------

// File: rtl/complex_op_packer_if.sv
// Handshake bundle between the word source, the operand packer and the complex multiplier.
// The master side is the packer: it consumes input words and drives packed operands.
interface complex_op_packer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    in_val;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_sof;
    logic                    op_val;
    logic                    op_ready;
    logic [4*DATA_WIDTH-1:0] op_data;

    modport master (
        input  in_val,
        input  in_data,
        input  in_sof,
        input  op_ready,
        output in_ready,
        output op_val,
        output op_data
    );

    modport slave (
        output in_val,
        output in_data,
        output in_sof,
        output op_ready,
        input  in_ready,
        input  op_val,
        input  op_data
    );
endinterface

// File: rtl/complex_op_packer.sv
// Packs four serial words into one {a_re, a_im, b_re, b_im} operand for the complex multiplier,
// double-buffered so a new operand can assemble while the previous one waits on op_ready.
//
// state | meaning
// EMPTY | output register empty, assembly register not holding a complete operand
// ONE   | output register holds a valid operand, assembly register filling or idle
// FULL  | output register valid and a complete operand parked in the assembly register
module complex_op_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sw_rst,
    complex_op_packer_if.master  bus,
    output logic                 frame_err,
    output logic [CNT_WIDTH-1:0] op_cnt
);

    localparam int DW  = DATA_WIDTH;
    localparam int OPW = 4 * DATA_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]           idx_q, idx_d;
    logic [OPW-1:0]       asm_q, asm_d;
    logic [OPW-1:0]       op_data_q, op_data_d;
    logic                 frame_err_q, frame_err_d;
    logic [CNT_WIDTH-1:0] op_cnt_q, op_cnt_d;

    logic           op_val;
    logic           asm_full;
    logic           in_ready;
    logic           free;
    logic           accept;
    logic           resync;
    logic [1:0]     word_idx;
    logic           complete;
    logic           handshake;
    logic [OPW-1:0] asm_placed;
    logic           load_new;
    logic           load_pend;

    // Status flags are pure decodes of the state, keeping them off any combinational loop.
    assign op_val    = (state_q != EMPTY);
    assign asm_full  = (state_q == FULL);
    assign in_ready  = ~asm_full & ~sw_rst;
    assign free      = ~op_val | bus.op_ready;
    assign handshake = op_val & bus.op_ready;

    assign accept    = bus.in_val & in_ready;
    assign resync    = accept & bus.in_sof & (idx_q != 2'd0);
    assign word_idx  = resync ? 2'd0 : idx_q;
    assign complete  = accept & (word_idx == 2'd3);

    // On resync the stale partial words are cleared, not just overwritten.
    always_comb begin
        asm_placed = resync ? '0 : asm_q;
        case (word_idx)
            2'd0:    asm_placed[4*DW-1:3*DW] = bus.in_data;
            2'd1:    asm_placed[3*DW-1:2*DW] = bus.in_data;
            2'd2:    asm_placed[2*DW-1:DW]   = bus.in_data;
            default: asm_placed[DW-1:0]      = bus.in_data;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (complete) begin
                    state_d = free ? ONE : FULL;
                end else if (bus.op_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (bus.op_ready) begin
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (sw_rst) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        load_new  = complete & free;
        load_pend = asm_full & free;
    end

    always_comb begin
        idx_d       = idx_q;
        asm_d       = asm_q;
        op_data_d   = op_data_q;
        frame_err_d = 1'b0;
        op_cnt_d    = op_cnt_q;
        if (sw_rst) begin
            idx_d     = 2'd0;
            asm_d     = '0;
            op_data_d = '0;
            op_cnt_d  = '0;
        end else begin
            if (accept) begin
                idx_d = word_idx + 2'd1;
                asm_d = asm_placed;
            end
            frame_err_d = resync;
            if (load_new) begin
                op_data_d = asm_placed;
            end else if (load_pend) begin
                op_data_d = asm_q;
            end
            if (handshake) begin
                op_cnt_d = op_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q       <= 2'd0;
            asm_q       <= '0;
            op_data_q   <= '0;
            frame_err_q <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            op_data_q   <= op_data_d;
            frame_err_q <= frame_err_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.op_val   = op_val;
    assign bus.op_data  = op_data_q;
    assign frame_err    = frame_err_q;
    assign op_cnt       = op_cnt_q;

endmodule

// File: tb/tb_complex_op_packer.sv
// Directed bench for complex_op_packer: hand-computed packing, backpressure, resync, wrap and soft reset.
module tb_complex_op_packer;

    logic       clk;
    logic       rstn;
    logic       sw_rst;
    logic       frame_err;
    logic [7:0] op_cnt;
    int         checks;
    int         failures;

    complex_op_packer_if #(.DATA_WIDTH(8)) bus ();

    complex_op_packer #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_rst    (sw_rst),
        .bus       (bus),
        .frame_err (frame_err),
        .op_cnt    (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic s);
        bus.in_val  = v;
        bus.in_data = d;
        bus.in_sof  = s;
    endtask

    task automatic send4(input logic [7:0] base, input logic sof);
        drive(1'b1, base, sof);
        step();
        drive(1'b1, base + 8'd1, 1'b0);
        step();
        drive(1'b1, base + 8'd2, 1'b0);
        step();
        drive(1'b1, base + 8'd3, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rstn         = 1'b1;
        sw_rst       = 1'b0;
        bus.in_val   = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_sof   = 1'b0;
        bus.op_ready = 1'b0;
        #2 rstn = 1'b0;
        #2;
        chk("rst_op_val", bus.op_val, 0);
        chk("rst_op_data", bus.op_data, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;

        // basic operand, latency 1 from the 4th word
        bus.op_ready = 1'b1;
        send4(8'h01, 1'b1);
        chk("t1_op_val", bus.op_val, 1);
        chk("t1_op_data", bus.op_data, 32'h01020304);
        chk("t1_cnt_pre", op_cnt, 0);
        step();
        chk("t1_val_drop", bus.op_val, 0);
        chk("t1_cnt", op_cnt, 1);

        // backpressure: second operand parks in the assembly register
        bus.op_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'h10 + 8'(i), i == 0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("t2_full_in_ready", bus.in_ready, 0);
        chk("t2_hold_data", bus.op_data, 32'h10111213);
        chk("t2_hold_val", bus.op_val, 1);
        step();
        chk("t2_hold_data2", bus.op_data, 32'h10111213);
        chk("t2_hold_cnt", op_cnt, 1);
        bus.op_ready = 1'b1;
        step();
        chk("t2_second_data", bus.op_data, 32'h14151617);
        chk("t2_second_val", bus.op_val, 1);
        chk("t2_cnt_a", op_cnt, 2);
        chk("t2_in_ready_back", bus.in_ready, 1);
        step();
        chk("t2_drop", bus.op_val, 0);
        chk("t2_cnt_b", op_cnt, 3);

        // resync on in_sof mid-operand
        drive(1'b1, 8'hAA, 1'b0);
        step();
        chk("t3_ferr_idle", frame_err, 0);
        drive(1'b1, 8'hBB, 1'b0);
        step();
        drive(1'b1, 8'h11, 1'b1);
        step();
        chk("t3_ferr_pulse", frame_err, 1);
        chk("t3_no_op", bus.op_val, 0);
        drive(1'b1, 8'h22, 1'b0);
        step();
        chk("t3_ferr_clear", frame_err, 0);
        drive(1'b1, 8'h33, 1'b0);
        step();
        drive(1'b1, 8'h44, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        chk("t3_op_data", bus.op_data, 32'h11223344);
        chk("t3_op_val", bus.op_val, 1);
        step();
        chk("t3_cnt", op_cnt, 4);

        // continuous streaming with op_ready high
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'h20 + 8'(i), i == 0);
            chk("t4_in_ready", bus.in_ready, 1);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("t4_last_data", bus.op_data, 32'h28292A2B);
        chk("t4_cnt_pre", op_cnt, 6);
        step();
        chk("t4_cnt", op_cnt, 7);

        // handshake and completion on the same edge keep op_val high
        bus.op_ready = 1'b0;
        send4(8'h50, 1'b1);
        drive(1'b1, 8'h54, 1'b1);
        step();
        drive(1'b1, 8'h55, 1'b0);
        step();
        drive(1'b1, 8'h56, 1'b0);
        step();
        chk("t5_still_first", bus.op_data, 32'h50515253);
        bus.op_ready = 1'b1;
        drive(1'b1, 8'h57, 1'b0);
        chk("t5_in_ready", bus.in_ready, 1);
        step();
        drive(1'b0, 8'h00, 1'b0);
        chk("t5_val_kept", bus.op_val, 1);
        chk("t5_data", bus.op_data, 32'h54555657);
        chk("t5_cnt_a", op_cnt, 8);
        step();
        chk("t5_drop", bus.op_val, 0);
        chk("t5_cnt_b", op_cnt, 9);

        // counter wrap
        for (int k = 0; k < 246; k++) begin
            send4(8'(k), 1'b1);
        end
        step();
        chk("t6_cnt_255", op_cnt, 255);
        send4(8'hC0, 1'b1);
        chk("t6_data", bus.op_data, 32'hC0C1C2C3);
        step();
        chk("t6_cnt_wrap", op_cnt, 0);

        // soft reset drops partial and pending operands
        send4(8'h60, 1'b1);
        step();
        chk("t7_cnt_pre", op_cnt, 1);
        bus.op_ready = 1'b0;
        send4(8'h30, 1'b1);
        drive(1'b1, 8'h34, 1'b1);
        step();
        drive(1'b1, 8'h35, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        chk("t7_pending", bus.op_val, 1);
        sw_rst = 1'b1;
        #1;
        chk("t7_swrst_in_ready", bus.in_ready, 0);
        step();
        sw_rst = 1'b0;
        #1;
        chk("t7_op_val", bus.op_val, 0);
        chk("t7_op_cnt", op_cnt, 0);
        chk("t7_op_data", bus.op_data, 0);
        chk("t7_in_ready", bus.in_ready, 1);
        bus.op_ready = 1'b1;
        send4(8'h40, 1'b0);
        chk("t7_fresh_data", bus.op_data, 32'h40414243);
        chk("t7_fresh_val", bus.op_val, 1);
        step();
        chk("t7_fresh_cnt", op_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
